// File: rtl/mnacid_pkg.sv
// rtl/mnacid_pkg.sv - state encoding, valve bit map and per-state open masks
package mnacid_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_LYSIS   = 4'd2,
    S_MIX     = 4'd3,
    S_WASH    = 4'd4,
    S_ELUTE   = 4'd5,
    S_COLLECT = 4'd6,
    S_FLUSH   = 4'd7
  } state_t;

  localparam int NUM_VALVES  = 11;
  localparam int V_LYSIS     = 0;
  localparam int V_WASH      = 1;
  localparam int V_ELUTE     = 2;
  localparam int V_DEAD_END  = 3;
  localparam int V_VERTICAL  = 4;
  localparam int V_HORIZ     = 5;
  localparam int V_WASTE     = 6;
  localparam int V_BEAD      = 7;
  localparam int V_LOOP_EXIT = 8;
  localparam int V_BEAD_TRAP = 9;
  localparam int V_COLLECT   = 10;

  // Masks mark valves that are open (deasserted) in each state.
  localparam logic [10:0] OPEN_LOAD    = 11'((1 << V_BEAD) | (1 << V_LOOP_EXIT) | (1 << V_WASTE));
  localparam logic [10:0] OPEN_LYSIS   = 11'((1 << V_LYSIS) | (1 << V_HORIZ) | (1 << V_WASTE));
  localparam logic [10:0] OPEN_MIX     = 11'((1 << V_VERTICAL) | (1 << V_HORIZ));
  localparam logic [10:0] OPEN_WASH    = 11'((1 << V_WASH) | (1 << V_BEAD_TRAP) | (1 << V_WASTE));
  localparam logic [10:0] OPEN_ELUTE   = 11'((1 << V_ELUTE) | (1 << V_BEAD_TRAP) | (1 << V_LOOP_EXIT));
  localparam logic [10:0] OPEN_COLLECT = 11'((1 << V_COLLECT) | (1 << V_LOOP_EXIT));
  localparam logic [10:0] OPEN_FLUSH   = 11'h7FF;

  function automatic logic [10:0] open_mask(input state_t s);
    case (s)
      S_LOAD:    return OPEN_LOAD;
      S_LYSIS:   return OPEN_LYSIS;
      S_MIX:     return OPEN_MIX;
      S_WASH:    return OPEN_WASH;
      S_ELUTE:   return OPEN_ELUTE;
      S_COLLECT: return OPEN_COLLECT;
      S_FLUSH:   return OPEN_FLUSH;
      default:   return 11'h000;
    endcase
  endfunction

  function automatic logic pump_state(input state_t s);
    return (s == S_MIX) || (s == S_WASH) || (s == S_ELUTE) || (s == S_COLLECT);
  endfunction

endpackage

// File: rtl/mnacid_seq_if.sv
// rtl/mnacid_seq_if.sv - host control and chip actuation bundle of the sequencer
interface mnacid_seq_if
  import mnacid_pkg::*;
#(
  parameter int SIZE        = 2,
  parameter int PUMP_PHASES = 3
);
  localparam int SEL_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic                              start;
  logic                              abort;
  logic                              pump_dir;
  logic [3:0]                        wash_reps;
  logic [SEL_W-1:0]                  collect_sel;
  logic [NUM_VALVES-1:0]             valve;
  logic [SIZE-1:0]                   collect_gate;
  logic [PUMP_PHASES-1:0]            pump;
  logic [NUM_VALVES+PUMP_PHASES-1:0] flush;
  logic                              busy;
  logic                              done;
  logic                              aborted;
  logic [3:0]                        state;

  modport master (
    output start, abort, pump_dir, wash_reps, collect_sel,
    input  valve, collect_gate, pump, flush, busy, done, aborted, state
  );

  modport slave (
    input  start, abort, pump_dir, wash_reps, collect_sel,
    output valve, collect_gate, pump, flush, busy, done, aborted, state
  );
endinterface

// File: rtl/mnacid_pump.sv
// rtl/mnacid_pump.sv - reversible peristaltic pump pattern with phase divider
module mnacid_pump #(
  parameter int PUMP_PHASES = 3,
  parameter int PUMP_DIV    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   dir,
  output logic [PUMP_PHASES-1:0] pump,
  output logic                   step
);
  localparam int PH_W  = $clog2(PUMP_PHASES);
  localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

  logic             running;
  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  phase_n;
  logic [DIV_W-1:0] div_cnt;

  // A step completes on the edge ending the last divider cycle of a phase.
  assign step = running && (div_cnt == DIV_W'(PUMP_DIV - 1));

  always_comb begin
    phase_n = phase;
    if (!enable) begin
      phase_n = '0;
    end else if (step) begin
      if (dir)
        phase_n = (phase == '0) ? PH_W'(PUMP_PHASES - 1) : phase - PH_W'(1);
      else
        phase_n = (phase == PH_W'(PUMP_PHASES - 1)) ? '0 : phase + PH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      phase   <= '0;
      div_cnt <= '0;
      pump    <= '1;
    end else begin
      running <= enable;
      phase   <= phase_n;
      if (!enable || !running || step)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DIV_W'(1);
      pump <= enable ? ~(PUMP_PHASES'(1) << phase_n) : '1;
    end
  end
endmodule

// File: rtl/mnacid_seq.sv
// rtl/mnacid_seq.sv - extraction protocol sequencer: FSM, step/wash counters, output registers
module mnacid_seq
  import mnacid_pkg::*;
#(
  parameter int SIZE        = 2,
  parameter int PUMP_PHASES = 3,
  parameter int PUMP_DIV    = 4,
  parameter int CNT_W       = 16,
  parameter int T_LOAD      = 8,
  parameter int T_LYSIS     = 8,
  parameter int T_WASH      = 8,
  parameter int T_ELUTE     = 8,
  parameter int T_COLLECT   = 8,
  parameter int T_FLUSH     = 8,
  parameter int MIX_STROKES = 4
) (
  input logic          clk,
  input logic          rst,
  mnacid_seq_if.slave  bus
);
  localparam int SEL_W     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int MIX_STEPS = MIX_STROKES * PUMP_PHASES;
  localparam int FLUSH_W   = NUM_VALVES + PUMP_PHASES;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        wash_left;
  logic [SEL_W-1:0]  sel_q, sel_in;
  logic              pump_step, expire, restart;
  logic              accept_start, accept_abort;
  logic [10:0]       valve_n;
  logic [SIZE-1:0]   gate_n;
  logic [FLUSH_W-1:0] flush_n;
  logic              busy_n, done_n;

  assign accept_start = (state_q == S_IDLE) && bus.start;
  assign accept_abort = bus.abort && (state_q != S_IDLE) && (state_q != S_FLUSH);
  assign sel_in = (int'(bus.collect_sel) >= SIZE) ? SEL_W'(SIZE - 1) : bus.collect_sel;
  assign bus.state = state_q;

  mnacid_pump #(.PUMP_PHASES(PUMP_PHASES), .PUMP_DIV(PUMP_DIV)) u_pump (
    .clk    (clk),
    .rst    (rst),
    .enable (pump_state(state_n)),
    .dir    (bus.pump_dir),
    .pump   (bus.pump),
    .step   (pump_step)
  );

  // MIX counts completed pump steps rather than cycles, so its length is direction independent.
  always_comb begin
    expire = 1'b0;
    case (state_q)
      S_LOAD:    expire = (cnt == CNT_W'(T_LOAD - 1));
      S_LYSIS:   expire = (cnt == CNT_W'(T_LYSIS - 1));
      S_MIX:     expire = pump_step && (cnt == CNT_W'(MIX_STEPS - 1));
      S_WASH:    expire = (cnt == CNT_W'(T_WASH - 1));
      S_ELUTE:   expire = (cnt == CNT_W'(T_ELUTE - 1));
      S_COLLECT: expire = (cnt == CNT_W'(T_COLLECT - 1));
      S_FLUSH:   expire = (cnt == CNT_W'(T_FLUSH - 1));
      default:   expire = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_n = S_LOAD;
      S_LOAD:    if (expire) state_n = S_LYSIS;
      S_LYSIS:   if (expire) state_n = S_MIX;
      S_MIX:     if (expire) state_n = (wash_left == 4'd0) ? S_ELUTE : S_WASH;
      S_WASH:    if (expire && wash_left == 4'd1) state_n = S_ELUTE;
      S_ELUTE:   if (expire) state_n = S_COLLECT;
      S_COLLECT: if (expire) state_n = S_FLUSH;
      S_FLUSH:   if (expire) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (accept_abort) state_n = S_FLUSH;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state register.
  always_comb begin
    valve_n = ~open_mask(state_n);
    gate_n  = '1;
    if (state_n == S_COLLECT) gate_n = ~(SIZE'(1) << sel_q);
    flush_n = (state_n == S_FLUSH) ? '1 : '0;
    busy_n  = (state_n != S_IDLE);
    done_n  = (state_q == S_FLUSH) && (state_n == S_IDLE);
  end

  // Each wash repetition restarts the step counter while the state and valves stay put.
  assign restart = (state_n != state_q) || ((state_q == S_WASH) && expire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt       <= '0;
      wash_left <= '0;
      sel_q     <= '0;
    end else begin
      state_q <= state_n;
      if (restart)
        cnt <= '0;
      else if (state_q != S_IDLE && (state_q != S_MIX || pump_step))
        cnt <= cnt + CNT_W'(1);
      if (accept_start) begin
        wash_left <= bus.wash_reps;
        sel_q     <= sel_in;
      end else if (state_q == S_WASH && expire) begin
        wash_left <= wash_left - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valve        <= '1;
      bus.collect_gate <= '1;
      bus.flush        <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.aborted      <= 1'b0;
    end else begin
      bus.valve        <= valve_n;
      bus.collect_gate <= gate_n;
      bus.flush        <= flush_n;
      bus.busy         <= busy_n;
      bus.done         <= done_n;
      if (accept_start)
        bus.aborted <= 1'b0;
      else if (accept_abort)
        bus.aborted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mnacid_seq.sv
// tb/tb_mnacid_seq.sv - scoreboard bench: expected state visits and pump patterns queued, monitor compares
module tb_mnacid_seq;
  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc_cnt = 0;
  int   done_cnt = 0;

  mnacid_seq_if #(.SIZE(2), .PUMP_PHASES(3)) bus ();

  mnacid_seq #(.SIZE(2), .PUMP_PHASES(3), .PUMP_DIV(4), .CNT_W(16),
               .T_LOAD(8), .T_LYSIS(8), .T_WASH(8), .T_ELUTE(8), .T_COLLECT(8),
               .T_FLUSH(8), .MIX_STROKES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0]  st;
    logic [10:0] valve;
    logic [1:0]  gate;
    logic [13:0] flush;
    logic        busy;
    logic        done;
    logic        aborted;
    int          dur;
  } exp_t;

  typedef struct {
    logic [2:0] val;
    int         hold;
  } pexp_t;

  exp_t  exp_q[$];
  pexp_t pump_q[$];
  exp_t  cur;
  pexp_t pcur;
  logic [3:0] prev_state = 4'd0;
  logic [2:0] prev_pump = 3'b111;
  int    cyc = 0;
  int    pcyc = 0;
  logic  pump_chk = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Hand-derived closed-valve patterns (1 = closed) per state.
  function automatic logic [10:0] exp_valve(input logic [3:0] s);
    case (s)
      4'd1:    return 11'h63F;
      4'd2:    return 11'h79E;
      4'd3:    return 11'h7CF;
      4'd4:    return 11'h5BD;
      4'd5:    return 11'h4FB;
      4'd6:    return 11'h2FF;
      4'd7:    return 11'h000;
      default: return 11'h7FF;
    endcase
  endfunction

  function automatic exp_t mk(input logic [3:0] s, input int dur, input logic [1:0] gate,
                              input logic ab, input logic dn);
    exp_t e;
    e.st      = s;
    e.valve   = exp_valve(s);
    e.gate    = gate;
    e.flush   = (s == 4'd7) ? 14'h3FFF : 14'h0000;
    e.busy    = (s != 4'd0);
    e.done    = dn;
    e.aborted = ab;
    e.dur     = dur;
    return e;
  endfunction

  task automatic push_proto(input int reps, input logic [1:0] cgate);
    exp_q.push_back(mk(4'd1, 8, 2'b11, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd2, 8, 2'b11, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd3, 48, 2'b11, 1'b0, 1'b0));
    if (reps != 0) exp_q.push_back(mk(4'd4, 8 * reps, 2'b11, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd5, 8, 2'b11, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd6, 8, cgate, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd7, 8, 2'b11, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd0, 0, 2'b11, 1'b0, 1'b1));
  endtask

  // Monitor: pops an expectation on every state change and checks outputs every cycle.
  always @(negedge clk) begin
    if (bus.state !== prev_state) begin
      if (cur.dur != 0) check("state_dur", cyc, cur.dur);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_state: got %0d want none", bus.state);
      end else begin
        cur = exp_q.pop_front();
      end
      cyc = 0;
      prev_state = bus.state;
    end
    check("state", bus.state, cur.st);
    check("valve", bus.valve, cur.valve);
    check("collect_gate", bus.collect_gate, cur.gate);
    check("flush", bus.flush, cur.flush);
    check("busy", bus.busy, cur.busy);
    check("aborted", bus.aborted, cur.aborted);
    check("done", bus.done, (cyc == 0) ? cur.done : 1'b0);
    if (bus.done === 1'b1) done_cnt++;
    if (!(bus.state inside {4'd3, 4'd4, 4'd5, 4'd6})) check("pump_idle", bus.pump, 3'b111);
    cyc++;

    if (pump_chk && bus.pump !== prev_pump) begin
      if (pcur.hold != 0) check("pump_hold", pcyc, pcur.hold);
      if (pump_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pump: got %0b want none", bus.pump);
      end else begin
        pcur = pump_q.pop_front();
        check("pump_pat", bus.pump, pcur.val);
      end
      pcyc = 0;
      prev_pump = bus.pump;
    end
    pcyc++;
  end

  task automatic wait_state(input logic [3:0] s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.state !== s && n < 300);
    if (bus.state !== s) check("wait_state", bus.state, s);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < 400);
    if (bus.done !== 1'b1) check("wait_done", bus.done, 1'b1);
  endtask

  task automatic start_proto(input logic [3:0] reps, input logic sel, input logic ab);
    @(negedge clk);
    bus.wash_reps   = reps;
    bus.collect_sel = sel;
    bus.start       = 1'b1;
    bus.abort       = ab;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, bus.state, 4'd0);
    check({tag, "_valve"}, bus.valve, 11'h7FF);
    check({tag, "_gate"}, bus.collect_gate, 2'b11);
    check({tag, "_pump"}, bus.pump, 3'b111);
    check({tag, "_flush"}, bus.flush, 14'h0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_aborted"}, bus.aborted, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int sel_raw;
    logic [2:0] ptab [3];
    int phs [16];
    ptab = '{3'b110, 3'b101, 3'b011};
    phs  = '{0, 1, 2, 0, 1, 2, 1, 0, 2, 1, 0, 2, 1, 0, 2, 1};
    cur  = mk(4'd0, 0, 2'b11, 1'b0, 1'b0);
    pcur.val = 3'b111;
    pcur.hold = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pump_dir = 1'b0;
    bus.wash_reps = 4'd0;
    bus.collect_sel = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // abort in IDLE is ignored
    @(negedge clk);
    bus.abort = 1'b1;
    repeat (2) @(negedge clk);
    bus.abort = 1'b0;
    check("idle_abort_aborted", bus.aborted, 1'b0);
    check("idle_abort_state", bus.state, 4'd0);

    // Run A: minimum protocol, pump direction reversed mid-MIX, start while busy ignored
    push_proto(0, 2'b10);
    for (int i = 0; i < 16; i++) pump_q.push_back('{val: ptab[phs[i]], hold: 4});
    pump_q.push_back('{val: 3'b111, hold: 0});
    pump_chk = 1'b1;
    start_proto(4'd0, 1'b0, 1'b0);
    t0 = cyc_cnt;
    wait_state(4'd2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_state(4'd3);
    repeat (21) @(posedge clk);
    #1 bus.pump_dir = 1'b1;
    wait_done();
    check("proto_cycles", cyc_cnt - t0, 88);
    pump_chk = 1'b0;
    bus.pump_dir = 1'b0;
    check("pump_q_empty", pump_q.size(), 0);

    // Run B: three wash repetitions, channel 1, start+abort together in IDLE
    push_proto(3, 2'b01);
    start_proto(4'd3, 1'b1, 1'b1);
    wait_done();

    // Run C: out-of-range select (3 on a one-bit port) lands on channel 1
    sel_raw = 3;
    push_proto(1, 2'b01);
    start_proto(4'd1, sel_raw[0], 1'b0);
    wait_done();

    // Run E: abort during LYSIS cycle 3
    exp_q.push_back(mk(4'd1, 8, 2'b11, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd2, 4, 2'b11, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd7, 8, 2'b11, 1'b1, 1'b0));
    exp_q.push_back(mk(4'd0, 0, 2'b11, 1'b1, 1'b1));
    start_proto(4'd2, 1'b0, 1'b0);
    wait_state(4'd2);
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_done();

    // Run D: new start clears aborted, then reset lands mid-MIX
    exp_q.push_back(mk(4'd1, 8, 2'b11, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd2, 8, 2'b11, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd3, 0, 2'b11, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd0, 0, 2'b11, 1'b0, 1'b0));
    start_proto(4'd2, 1'b0, 1'b0);
    wait_state(4'd3);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("midmix_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("exp_q_empty", exp_q.size(), 0);
    check("done_pulses", done_cnt, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mnacid_seq.md
# mnacid_seq

Protocol sequencer for the nucleic-acid extraction chip family, parameterised in collect-channel count (SIZE) and pump phase count. It drives the chip's control lines from a single synchronous FSM, which sequences bead load, lysis, pumped mixing, repeated wash, elution, per-channel collection and flush. It also generates a reversible peristaltic pump pattern and supports abort-to-flush. It sits between the host/test controller and the chip's pneumatic control and flush inputs.

## Interface
- SIZE, 2, number of collect outputs (≥1)
- PUMP_PHASES, 3, peristaltic pump valves (≥3)
- PUMP_DIV, 4, clock cycles per pump phase (≥1)
- CNT_W, 16, step counter width
- T_LOAD, T_LYSIS, T_WASH, T_ELUTE, T_COLLECT, T_FLUSH, 8 each, state durations in cycles (1..2^CNT_W-1)
- MIX_STROKES, 4, full pump revolutions in MIX (≥1)

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin protocol; sampled only in IDLE
- abort  in  1  jump to FLUSH from any active state
- pump_dir  in  1  0 = forward, 1 = reverse; sampled every phase step
- wash_reps  in  4  wash repetitions; latched at start; 0 skips WASH
- collect_sel  in  $clog2(SIZE) (min 1)  target channel; latched at start; values ≥SIZE clamp to SIZE-1
- valve  out  11  1 = actuated/closed. Bit map: 0 lysis, 1 wash, 2 elute, 3 dead_end, 4 vertical, 5 horiz, 6 waste, 7 bead, 8 loop_exit, 9 bead_trap, 10 collect
- collect_gate  out  SIZE  1 = closed, per channel
- pump  out  PUMP_PHASES  1 = closed
- flush  out  11+PUMP_PHASES  flush strobes, same bit map, pump bits on top
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on FLUSH exit
- aborted  out  1  sticky from abort until next accepted start
- state  out  4  current state encoding

## Operation
- States: IDLE=0, LOAD=1, LYSIS=2, MIX=3, WASH=4, ELUTE=5, COLLECT=6, FLUSH=7.
- Sequence: IDLE →(start) LOAD → LYSIS → MIX → WASH (×wash_reps; skipped if 0) → ELUTE → COLLECT → FLUSH → IDLE, with done pulsed on the FLUSH→IDLE edge.
- Open valves per state; all others closed:
  - LOAD: bead, loop_exit, waste.
  - LYSIS: lysis, horiz, waste.
  - MIX: vertical, horiz.
  - WASH: wash, bead_trap, waste.
  - ELUTE: elute, bead_trap, loop_exit.
  - COLLECT: collect, loop_exit, plus collect_gate[sel].
  - FLUSH: all open, flush all 1.
  - IDLE: all closed, flush 0.
- Pump runs in MIX, WASH, ELUTE and COLLECT. In every other state it is all-closed and the phase index resets to 0.
- Pump pattern: exactly one valve open, pump = ~(1<<phase). Phase advances every PUMP_DIV cycles: +1 mod PUMP_PHASES when forward, -1 mod PUMP_PHASES when reverse.
- MIX lasts MIX_STROKES×PUMP_PHASES×PUMP_DIV cycles. It is counted in completed phase steps, independent of direction.
- Abort: from any state other than IDLE or FLUSH, go to FLUSH next cycle, set aborted, and restart the FLUSH counter. Abort in IDLE or FLUSH is ignored.
- start while busy is ignored. Simultaneous start and abort in IDLE: start wins.

## Timing
- All outputs registered. They reflect the new state on the first cycle the state register holds it.
- start at edge k: busy=1 and state=LOAD from edge k+1.
- Each timed state holds exactly T_x cycles.
- Each wash repetition holds T_WASH cycles, and the valve pattern is held continuously across repetitions.
- The wash repetition counter decrements on each T_WASH expiry. ELUTE is entered when the counter reaches 0.
- Minimum protocol (wash_reps=0): T_LOAD+T_LYSIS+MIX+T_ELUTE+T_COLLECT+T_FLUSH cycles. done is high in the first IDLE cycle.
- Reset values: state=IDLE, valve=all 1, collect_gate=all 1, pump=all 1, flush=0, busy=0, done=0, aborted=0, all counters 0.
- Reset mid-protocol returns to these values immediately, with no flush.

## Structure
- Package mnacid_pkg holds:
  - state encoding constants;
  - valve bit-index constants;
  - per-state open-mask constants, 11-bit.
- Sub-module mnacid_pump:
  - inputs: clk, rst, enable, dir;
  - outputs: pump pattern and a step strobe.
  - It owns the divider and phase counter, and returns to phase 0 when enable drops.
- The top module holds the FSM, step/wash counters, latches and output registers.

## Test plan
- Reset with SIZE=2, all T=8, MIX_STROKES=4, PUMP_DIV=4, wash_reps=0, start -> state sequence 1,2,3,5,6,7,0. MIX lasts 48 cycles, done pulses once, total 88 cycles.
- wash_reps=3 -> WASH lasts 24 cycles with the valve pattern constant throughout. ELUTE begins exactly 24 cycles after MIX ends.
- pump_dir=0 in MIX -> pump cycles 110,101,011, each held 4 cycles. Switching pump_dir=1 mid-MIX -> the next step reverses to the previous pattern.
- collect_sel=1 -> collect_gate=01 only during COLLECT. collect_sel=3 with SIZE=2 clamps to channel 1.
- abort in LYSIS cycle 3 -> FLUSH next cycle with flush all 1, aborted=1, FLUSH lasts 8 cycles, then done. A new start clears aborted.
- rst asserted mid-MIX -> outputs reach reset values asynchronously. start during busy and abort in IDLE have no effect.
